// File: rtl/controller_fsm_if.sv
// Control bus between the instruction sequencer and the PC / IR / datapath blocks.
// The sequencer is the master: it consumes IR and drives every strobe and address.
interface controller_fsm_if;
    logic [15:0] IR;
    logic        PC_clr;
    logic        PC_up;
    logic        IR_ld;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  State;

    modport master (
        input  IR,
        output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, State
    );

    modport slave (
        output IR,
        input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, State
    );
endinterface

// File: rtl/controller_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit processor control unit.
// Moore FSM; execute-state outputs additionally pass through IR address fields.
module controller_fsm (
    input  logic               Clock,
    input  logic               Clear,
    controller_fsm_if.master   bus
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_reg <= S_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                // Unused opcodes 6..15 fall through to NOOP.
                case (bus.IR[15:12])
                    4'h1:    state_next = S_STORE;
                    4'h2:    state_next = S_LOADA;
                    4'h3:    state_next = S_ADD;
                    4'h4:    state_next = S_SUB;
                    4'h5:    state_next = S_HALT;
                    default: state_next = S_NOOP;
                endcase
            end
            S_LOADA:  state_next = S_LOADB;
            S_LOADB,
            S_STORE,
            S_ADD,
            S_SUB,
            S_NOOP:   state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_INIT;
        endcase
    end

    always_comb begin
        bus.PC_clr     = 1'b0;
        bus.PC_up      = 1'b0;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = 8'h00;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = 4'h0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = 4'h0;
        bus.RF_Rb_addr = 4'h0;
        bus.ALU_s0     = 3'b000;
        case (state_reg)
            S_INIT: begin
                bus.PC_clr = 1'b1;
            end
            S_FETCH: begin
                bus.IR_ld = 1'b1;
                bus.PC_up = 1'b1;
            end
            S_LOADA: begin
                bus.D_addr    = bus.IR[11:4];
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = bus.IR[3:0];
            end
            S_LOADB: begin
                // Second LOAD cycle: RAM read data is now valid, commit it.
                bus.D_addr    = bus.IR[11:4];
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = bus.IR[3:0];
                bus.RF_W_en   = 1'b1;
            end
            S_STORE: begin
                bus.D_addr     = bus.IR[7:0];
                bus.RF_Ra_addr = bus.IR[11:8];
                bus.D_wr       = 1'b1;
            end
            S_ADD: begin
                bus.RF_Ra_addr = bus.IR[11:8];
                bus.RF_Rb_addr = bus.IR[7:4];
                bus.RF_W_addr  = bus.IR[3:0];
                bus.RF_W_en    = 1'b1;
                bus.ALU_s0     = 3'b001;
            end
            S_SUB: begin
                bus.RF_Ra_addr = bus.IR[11:8];
                bus.RF_Rb_addr = bus.IR[7:4];
                bus.RF_W_addr  = bus.IR[3:0];
                bus.RF_W_en    = 1'b1;
                bus.ALU_s0     = 3'b010;
            end
            default: begin
            end
        endcase
    end

    assign bus.State = state_reg;

endmodule
